// File: rtl/crosswalk_request_scheduler.sv
// Crosswalk button debounce, pending-request latch and walk-phase handshake scheduler.
// Define SCHED_FIXED_PRIORITY_EN to replace round-robin arbitration with lowest-index-first.
module crosswalk_request_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int GRANT_HOLD   = 10,
    parameter int ACK_TIMEOUT  = 63
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] button_n_i,
    input  logic [NUM_REQ-1:0] phase_ok_i,
    input  logic               ext_ack_i,
    output logic               ext_req_o,
    output logic [1:0]         ext_req_id_o,
    output logic [NUM_REQ-1:0] walk_grant_o,
    output logic [NUM_REQ-1:0] pending_o,
    output logic               busy_o
);

    // state  | meaning
    // IDLE   | nothing in flight; leave as soon as any request is pending
    // ARB    | one cycle: pick an eligible pending request or fall back to IDLE
    // REQ    | ext_req raised for the latched id, waiting for ext_ack
    // WALK   | walk_grant held for the latched id
    // CLEAR  | one cycle: grant is low, remember the served id for round-robin
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_WALK, S_CLEAR} state_t;

    localparam logic [7:0] DB_FULL   = 8'(DEBOUNCE_CNT);
    localparam logic [7:0] HOLD_INIT = 8'(GRANT_HOLD);
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [NUM_REQ-1:0] sync1_q, sync2_q;
    logic [7:0]         db_cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] pressed, pressed_q, press_evt;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] eligible, grant_clr, press_block;
    logic [1:0]         winner;

    state_t             state_q;
    logic [1:0]         id_q, last_grant_q;
    logic [7:0]         wait_q, hold_q;
    logic               ext_req_q, busy_q;
    logic [NUM_REQ-1:0] walk_grant_q;

    // Synchroniser idles high so reset does not look like a held button.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            pressed_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= button_n_i;
            sync2_q   <= sync1_q;
            pressed_q <= pressed;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sync2_q[i])
                    db_cnt_q[i] <= '0;
                else if (!pressed[i])
                    db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) pressed[i] = (db_cnt_q[i] == DB_FULL);
        press_evt = pressed & ~pressed_q;
    end

    always_comb begin
        grant_clr   = '0;
        press_block = '0;
        if (state_q == S_REQ && ext_ack_i) begin
            grant_clr   = 4'b0001 << id_q;
            press_block = 4'b0001 << id_q;
        end else if (state_q == S_WALK) begin
            press_block = 4'b0001 << id_q;
        end
        pending_d = (pending_q | (press_evt & ~press_block)) & ~grant_clr;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    always_comb begin
        eligible = pending_q & phase_ok_i;
        winner   = '0;
`ifdef SCHED_FIXED_PRIORITY_EN
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (eligible[k]) winner = 2'(k);
`else
        // Offsets scanned largest first so the nearest index after last_grant wins.
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (eligible[last_grant_q + 2'(k + 1)]) winner = last_grant_q + 2'(k + 1);
`endif
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            last_grant_q <= 2'd3;
            wait_q       <= '0;
            hold_q       <= '0;
            ext_req_q    <= 1'b0;
            walk_grant_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|pending_q) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (eligible == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        id_q      <= winner;
                        wait_q    <= '0;
                        ext_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ext_ack_i) begin
                        ext_req_q    <= 1'b0;
                        walk_grant_q <= 4'b0001 << id_q;
                        hold_q       <= HOLD_INIT;
                        state_q      <= S_WALK;
                    end else if (!phase_ok_i[id_q] || wait_q == WAIT_LAST) begin
                        ext_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_WALK: begin
                    if (!phase_ok_i[id_q] || hold_q == 8'd1) begin
                        walk_grant_q <= '0;
                        state_q      <= S_CLEAR;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                S_CLEAR: begin
                    last_grant_q <= id_q;
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                end
                default: begin
                    ext_req_q    <= 1'b0;
                    walk_grant_q <= '0;
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ext_req_o    = ext_req_q;
    assign ext_req_id_o = id_q;
    assign walk_grant_o = walk_grant_q;
    assign pending_o    = pending_q;
    assign busy_o       = busy_q;

endmodule
